// File: rtl/bcd_10_2_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest width able to hold 10^digits - 1, i.e. ceil(log2(10^digits)).
    function automatic int bin_width(input int digits);
        longint unsigned p;
        int              w;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < p) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_10_2_mac10.sv
// Combinational multiply-by-ten-and-add step: accOut = accIn*10 + digit,
// built from two shifted copies of the accumulator, wrapping at BIN_W bits.
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic [BIN_W-1:0] accIn,
    input  bcd_digit_t       digit,
    output logic [BIN_W-1:0] accOut
);

    // acc*8 + acc*2 + digit; raw nibble values A-F are weighted as-is.
    assign accOut = (accIn << 3) + (accIn << 1) + BIN_W'(digit);

endmodule

// File: rtl/bcd_10_2.sv
// Digit-serial packed-BCD to binary converter. A word is captured on start,
// then one digit (most significant first) is folded into the accumulator per
// clock. The result and an invalid-digit flag are registered on completion
// and accompanied by a one-cycle done pulse.
module bcd_10_2
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcdIn,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      binOut,
    output logic                  err
);

    localparam int SR_W  = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    if (BIN_W < bin_width(DIGITS)) begin : g_bin_w_check
        $error("bcd_10_2: BIN_W too small to hold 10^DIGITS - 1");
    end

    state_t            state_q,  state_d;
    logic [BIN_W-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [SR_W-1:0]   sr_q,     sr_d;
    logic [BIN_W-1:0]  bin_q,    bin_d;
    logic              err_q,    err_d;
    logic              errp_q,   errp_d;

    logic [BIN_W-1:0]  mac_out;
    logic              in_invalid;

    // True when any nibble of the word is outside 0..9.
    function automatic logic has_invalid(input logic [SR_W-1:0] w);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] > BCD_MAX) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign in_invalid = has_invalid(bcdIn);

    bcd_mac10 #(
        .BIN_W (BIN_W)
    ) u_mac (
        .accIn  (acc_q),
        .digit  (sr_q[SR_W-1 -: 4]),
        .accOut (mac_out)
    );

    // Next-state logic: capture on start (IDLE or DONE), fold one digit per RUN cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bin_d   = bin_q;
        err_d   = err_q;
        errp_d  = errp_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    sr_d    = bcdIn;
                    acc_d   = '0;
                    cnt_d   = '0;
                    errp_d  = in_invalid;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = mac_out;
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    bin_d   = mac_out;
                    err_d   = errp_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything including the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            errp_q  <= errp_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign binOut = bin_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_10_2.sv
// Bench for bcd_10_2: vector table, directed multi-cycle sequences, random
// words against an arithmetic reference, and a one-digit instance.
module tb_bcd_10_2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcdIn;
    logic        busy;
    logic        done;
    logic [13:0] binOut;
    logic        err;

    logic        start1;
    logic [3:0]  bcd1;
    logic        busy1;
    logic        done1;
    logic [3:0]  bin1;
    logic        err1;

    int n_pass;
    int n_total;

    bcd_10_2 #(.DIGITS(4), .BIN_W(14)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bcdIn  (bcdIn),
        .busy   (busy),
        .done   (done),
        .binOut (binOut),
        .err    (err)
    );

    bcd_10_2 #(.DIGITS(1), .BIN_W(4)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .bcdIn  (bcd1),
        .busy   (busy1),
        .done   (done1),
        .binOut (bin1),
        .err    (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        int          exp_bin;
        bit          exp_err;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Reference: positional decimal value of the nibbles, reduced mod 2^14.
    task automatic model(input logic [15:0] b, output int v, output bit e);
        longint s;
        longint wt;
        int     nib;
        s  = 0;
        wt = 1;
        e  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nib = int'(b[4*i +: 4]);
            s   = s + nib * wt;
            wt  = wt * 10;
            if (nib > 9) e = 1'b1;
        end
        v = int'(s % 16384);
    endtask

    // One conversion from IDLE; returns result, flag, edges until done, busy cycles.
    task automatic run_conv(input logic [15:0] b, output int got, output bit e,
                            output int lat, output int nbusy);
        @(negedge clk);
        bcdIn = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 20) begin
            if (busy) nbusy++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1);
        got = int'(binOut);
        e   = err;
    endtask

    int  got, lat, nb, ev, c, npulse, seen_bin;
    bit  ge, ee;
    logic [13:0] hold;
    logic [15:0] rb;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        start   = 1'b0;
        bcdIn   = '0;
        start1  = 1'b0;
        bcd1    = '0;

        vt[0] = '{16'h9999, 9999, 1'b0};
        vt[1] = '{16'h0000, 0,    1'b0};
        vt[2] = '{16'h1234, 1234, 1'b0};
        vt[3] = '{16'h12A4, 1304, 1'b1};
        vt[4] = '{16'h0042, 42,   1'b0};
        vt[5] = '{16'hFFFF, 281,  1'b1};
        vt[6] = '{16'h1A00, 2000, 1'b1};
        vt[7] = '{16'h0999, 999,  1'b0};

        #12;
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_binOut", binOut, 0);
        chk("rst_err",    err,    0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_conv(vt[i].bcd, got, ge, lat, nb);
            chk($sformatf("vec%0d_bin", i), got, vt[i].exp_bin);
            chk($sformatf("vec%0d_err", i), ge,  vt[i].exp_err);
            chk($sformatf("vec%0d_lat", i), lat, 4);
            chk($sformatf("vec%0d_busy", i), nb, 4);
        end

        // Result holds while idle.
        hold = binOut;
        repeat (3) @(negedge clk);
        chk("idle_hold_bin", binOut, hold);
        chk("idle_busy", busy, 0);

        // Back-to-back: second start asserted during the DONE cycle.
        @(negedge clk);
        bcdIn = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!done && c < 20) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_first_bin", binOut, 0);
        bcdIn = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (!done && c < 20) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        chk("b2b_spacing", c, 5);
        chk("b2b_second_bin", binOut, 1234);

        // Start during RUN is ignored.
        @(negedge clk);
        bcdIn = 16'h5678;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bcdIn = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        npulse   = 0;
        seen_bin = -1;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                npulse++;
                seen_bin = int'(binOut);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("ignore_pulses", npulse, 1);
        chk("ignore_bin", seen_bin, 5678);

        // Asynchronous abort mid-RUN.
        @(negedge clk);
        bcdIn = 16'h9999;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy",   busy,   0);
        chk("abort_done",   done,   0);
        chk("abort_binOut", binOut, 0);
        chk("abort_err",    err,    0);
        @(negedge clk);
        rst = 1'b1;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        chk("abort_no_done", npulse, 0);
        run_conv(16'h0007, got, ge, lat, nb);
        chk("after_abort_bin", got, 7);
        chk("after_abort_err", ge, 0);

        // Randomized words against the arithmetic reference.
        for (int k = 0; k < 30; k++) begin
            rb = 16'($urandom);
            if (k % 2 == 0) begin
                for (int d = 0; d < 4; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            model(rb, ev, ee);
            run_conv(rb, got, ge, lat, nb);
            chk($sformatf("rnd%0d_bin_%h", k, rb), got, ev);
            chk($sformatf("rnd%0d_err_%h", k, rb), ge, ee);
            chk($sformatf("rnd%0d_lat", k), lat, 4);
        end

        // Single-digit instance.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            bcd1   = (t == 0) ? 4'h9 : 4'hC;
            start1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 20) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            chk($sformatf("d1_t%0d_lat", t), lat, 1);
            chk($sformatf("d1_t%0d_bin", t), bin1, (t == 0) ? 9 : 12);
            chk($sformatf("d1_t%0d_err", t), err1, (t == 0) ? 0 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
